fs_motor_monitor: RTL and testbench
===================================

Name: fs_motor_monitor

Overview:
Passive monitor that receives the 4-wire full-step coil pattern produced by the stepper phase driver, on pins or looped back, and decodes it into step events. Provides step direction, a signed position count, a motion flag and sticky fault flags for skipped steps and illegal coil patterns. Sits beside the motor driver in the stabiliser design for closed-loop checking and position telemetry.

Parameters:
FILT_LEN, 4, consecutive identical synchronised samples required before a coil pattern is accepted (1..15)
POS_W, 16, width of signed position counter
TIMEOUT, 50000, cycles without a step after which moving deasserts (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ph_in  input  4  coil pattern {f3,f2,f1,f0} (blue, yellow, pink, orange); asynchronous to clk
pos_clr  input  1  synchronous clear of position to 0
err_clr  input  1  clears err_skip and err_pattern
step_stb  output  1  one-cycle pulse per decoded single step
step_dir  output  1  direction of the last step: 0 = forward (index +1), 1 = reverse (index -1)
position  output  POS_W  signed step count: +1 forward, -1 reverse
locked  output  1  monitor is tracking a valid pattern (state TRACK)
moving  output  1  a step occurred within the last TIMEOUT cycles
err_skip  output  1  sticky; a +/-2 index jump was seen
err_pattern  output  1  sticky; a non-zero illegal pattern was accepted

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, synchronisers 0, filter candidate 0000 with count 0, timer 0.
- Reset applied mid-operation returns the block to these same values. No step is emitted on the first pattern after reset.
- Sync: ph_in passes through a 2-FF synchroniser per bit, giving s.
- Filter: if s != cand, then cand <= s and cnt <= 1. Else cnt saturates at FILT_LEN. filt <= cand on the edge where cnt reaches FILT_LEN.
- Pattern map: 0011->idx0, 0110->idx1, 1100->idx2, 1001->idx3. 0000 = released. Any other value = illegal.
- Decode is registered. step_stb and position update 1 cycle after filt changes. Total latency from a ph_in change to step_stb = 3+FILT_LEN edges (7 at default).
- FSM IDLE:
  - filt becomes a valid pattern -> TRACK, load idx, no step.
  - 0000 -> stay in IDLE.
  - illegal -> err_pattern <= 1, stay in IDLE.
- FSM TRACK, on each filt change:
  - delta = (new_idx - idx) mod 4.
  - delta 1 -> step_stb, step_dir 0, position +1.
  - delta 3 -> step_stb, step_dir 1, position -1.
  - delta 2 -> err_skip <= 1, idx updated, no step, no count.
  - 0000 -> IDLE, no error.
  - illegal -> IDLE, err_pattern <= 1.
- position wraps in two's complement; no saturation.
- pos_clr has priority over a same-cycle step: position = 0, step_stb still pulses, step_dir still updates.
- Error set has priority over err_clr in the same cycle: the flag stays 1.
- moving: timer reloads to TIMEOUT on each step_stb and decrements to 0. moving = (timer != 0). Leaving TRACK does not clear moving early.
- step_dir holds its value between steps.

Decomposition:
- Shared package fs_motor_pkg:
  - pattern constants PH_IDX0..PH_IDX3 = 4'b0011, 4'b0110, 4'b1100, 4'b1001 and PH_OFF = 4'b0000
  - state encoding ST_IDLE, ST_TRACK
  - direction constants DIR_FWD = 0, DIR_REV = 1
- The driver and this monitor share these constants.
- One sub-module, fs_phase_filter: 2-FF synchroniser plus FILT_LEN stability filter on the 4-bit bus, outputting filt and a one-cycle filt_chg.

Test Plan:
- Reset, then ph_in 0011 held -> locked=1 at edge 7, step_stb never pulses, position=0.
- Forward sequence 0011,0110,1100,1001,0011, each held 20 cycles -> 4 step_stb pulses with step_dir=0, position=4, moving=1. TIMEOUT=100: moving=0 100 cycles after the last pulse.
- Reverse sequence 0011,1001,1100,0110 -> 3 pulses with step_dir=1, position=-3. With POS_W=4 and position=-8, one more reverse step -> position=7 (wrap).
- Glitches: 3-cycle 0110 glitch on steady 0011 (FILT_LEN=4) -> no step, no error. 0011 -> 1100 jump -> err_skip=1, position unchanged; the next 1001 counts +1.
- 0011 -> 0111 held -> err_pattern=1, locked=0. Then 0000 -> no error change. err_clr -> flags 0. 0011 re-locks with no step.
- pos_clr asserted on the same cycle as a forward step_stb -> position=0. err_clr on the same cycle as a new skip -> err_skip=1. rst asserted mid-sequence -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fs_motor_pkg.sv
// Shared constants and types for the full-step phase driver and monitor.
// Coil patterns, FSM states, step direction and a pattern decoder.
package fs_motor_pkg;

  localparam logic [3:0] PH_IDX0 = 4'b0011;
  localparam logic [3:0] PH_IDX1 = 4'b0110;
  localparam logic [3:0] PH_IDX2 = 4'b1100;
  localparam logic [3:0] PH_IDX3 = 4'b1001;
  localparam logic [3:0] PH_OFF  = 4'b0000;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PK_OFF,
    PK_VALID,
    PK_ILLEGAL
  } ph_kind_e;

  typedef struct packed {
    ph_kind_e   kind;
    logic [1:0] idx;
  } ph_dec_t;

  function automatic ph_dec_t ph_decode(input logic [3:0] ph);
    ph_dec_t d;
    d.kind = PK_ILLEGAL;
    d.idx  = 2'd0;
    case (ph)
      PH_IDX0: begin d.kind = PK_VALID; d.idx = 2'd0; end
      PH_IDX1: begin d.kind = PK_VALID; d.idx = 2'd1; end
      PH_IDX2: begin d.kind = PK_VALID; d.idx = 2'd2; end
      PH_IDX3: begin d.kind = PK_VALID; d.idx = 2'd3; end
      PH_OFF:  d.kind = PK_OFF;
      default: d.kind = PK_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fs_motor_monitor_filter.sv
// fs_phase_filter: 2-FF synchroniser and stability filter on the coil bus.
// filt_o only takes a pattern seen FILT_LEN consecutive times.
module fs_phase_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ph_i,
  output logic [3:0] filt_o,
  output logic       filt_chg_o
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, chg_d;

  // Track the candidate pattern and accept it once it has been stable.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    chg_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CNT_MAX) begin
      filt_d = cand_d;
      chg_d  = (cand_d != filt_q);
    end
  end

  // Synchroniser, filter and change-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= ph_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      chg_q   <= chg_d;
    end
  end

  assign filt_o     = filt_q;
  assign filt_chg_o = chg_q;

endmodule

// File: rtl/fs_motor_monitor.sv
// Full-step coil pattern monitor: decodes steps, direction and position.
// Flags skipped steps and illegal patterns; reports recent motion.
module fs_motor_monitor
  import fs_motor_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int POS_W    = 16,
  parameter int TIMEOUT  = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ph_in,
  input  logic             pos_clr,
  input  logic             err_clr,
  output logic             step_stb,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic             locked,
  output logic             moving,
  output logic             err_skip,
  output logic             err_pattern
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0] filt;
  logic       filt_chg;
  ph_dec_t    dec;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       delta;
  logic             stb_q, stb_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             eskip_q, eskip_d;
  logic             epat_q, epat_d;
  logic             skip_set, pat_set;
  logic [TW-1:0]    timer_q, timer_d;

  fs_phase_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk        (clk),
    .rst        (rst),
    .ph_i       (ph_in),
    .filt_o     (filt),
    .filt_chg_o (filt_chg)
  );

  assign dec   = ph_decode(filt);
  assign delta = dec.idx - idx_q;

  // Next state: step decode, position, sticky errors and motion timer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stb_d    = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    skip_set = 1'b0;
    pat_set  = 1'b0;
    if (filt_chg) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            dec.kind == PK_VALID: begin
              state_d = ST_TRACK;
              idx_d   = dec.idx;
            end
            dec.kind == PK_ILLEGAL: pat_set = 1'b1;
            default: ;
          endcase
        end
        ST_TRACK: begin
          if (dec.kind == PK_VALID) begin
            idx_d = dec.idx;
            case (delta)
              2'd1: begin
                stb_d = 1'b1;
                dir_d = DIR_FWD;
                pos_d = pos_q + POS_W'(1);
              end
              2'd3: begin
                stb_d = 1'b1;
                dir_d = DIR_REV;
                pos_d = pos_q - POS_W'(1);
              end
              2'd2: skip_set = 1'b1;
              default: ;
            endcase
          end else begin
            state_d = ST_IDLE;
            pat_set = (dec.kind == PK_ILLEGAL);
          end
        end
      endcase
    end
    if (pos_clr) begin
      pos_d = '0;
    end
    eskip_d = skip_set | (eskip_q & ~err_clr);
    epat_d  = pat_set | (epat_q & ~err_clr);
    if (stb_d) begin
      timer_d = TW'(TIMEOUT);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      eskip_q <= 1'b0;
      epat_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      eskip_q <= eskip_d;
      epat_q  <= epat_d;
      timer_q <= timer_d;
    end
  end

  assign step_stb    = stb_q;
  assign step_dir    = dir_q;
  assign position    = pos_q;
  assign locked      = (state_q == ST_TRACK);
  assign moving      = (timer_q != '0);
  assign err_skip    = eskip_q;
  assign err_pattern = epat_q;

endmodule

// File: tb/tb_fs_motor_monitor.sv
// Bench for fs_motor_monitor: directed and random coil sequences
// checked every cycle against a behavioural step model.
module tb_fs_motor_monitor;

  localparam int FL = 4;
  localparam int PW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ph_in = 4'd0;
  logic          pos_clr = 1'b0;
  logic          err_clr = 1'b0;
  logic          step_stb, step_dir, locked, moving;
  logic          err_skip, err_pattern;
  logic [PW-1:0] position;

  fs_motor_monitor #(
    .FILT_LEN (FL),
    .POS_W    (PW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ph_in       (ph_in),
    .pos_clr     (pos_clr),
    .err_clr     (err_clr),
    .step_stb    (step_stb),
    .step_dir    (step_dir),
    .position    (position),
    .locked      (locked),
    .moving      (moving),
    .err_skip    (err_skip),
    .err_pattern (err_pattern)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int stb_seen = 0;

  int m_hist[FL+2];
  int m_filt, m_idx, m_pos, edge_n, last_step;
  bit m_chg, m_lock, m_stb, m_dir, m_eskip, m_epat, any_step;

  int pats[4] = '{3, 6, 12, 9};

  function automatic int ph_idx(int v);
    case (v)
      3:  return 0;
      6:  return 1;
      12: return 2;
      9:  return 3;
      0:  return -1;
      default: return -2;
    endcase
  endfunction

  function automatic int wrap(int v);
    int m;
    m = 1 << PW;
    v = ((v % m) + m) % m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  task automatic model_edge();
    int k, d;
    bit stable, sk, pt;
    edge_n++;
    if (rst) begin
      foreach (m_hist[i]) m_hist[i] = 0;
      m_filt = 0; m_chg = 0; m_lock = 0; m_idx = 0;
      m_pos = 0; m_stb = 0; m_dir = 0;
      m_eskip = 0; m_epat = 0; any_step = 0;
      return;
    end
    m_stb = 0; sk = 0; pt = 0;
    if (m_chg) begin
      k = ph_idx(m_filt);
      if (!m_lock) begin
        if (k >= 0) begin
          m_lock = 1;
          m_idx = k;
        end else if (k == -2) pt = 1;
      end else if (k >= 0) begin
        d = (k - m_idx + 4) % 4;
        if (d == 1) begin m_stb = 1; m_dir = 0; m_pos++; end
        else if (d == 3) begin m_stb = 1; m_dir = 1; m_pos--; end
        else if (d == 2) sk = 1;
        m_idx = k;
      end else begin
        m_lock = 0;
        pt = (k == -2);
      end
    end
    if (pos_clr) m_pos = 0;
    m_pos = wrap(m_pos);
    m_eskip = sk | (m_eskip & !err_clr);
    m_epat = pt | (m_epat & !err_clr);
    if (m_stb) begin
      any_step = 1;
      last_step = edge_n;
    end
    for (int i = FL + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(ph_in);
    stable = 1;
    for (int i = 3; i <= FL + 1; i++)
      if (m_hist[i] != m_hist[2]) stable = 0;
    m_chg = stable && (m_hist[2] != m_filt);
    if (stable) m_filt = m_hist[2];
  endtask

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("step_stb", step_stb, m_stb);
    chk("step_dir", step_dir, m_dir);
    chk("position", $signed(position), m_pos);
    chk("locked", locked, m_lock);
    chk("moving", moving, any_step && (edge_n - last_step) < TO);
    chk("err_skip", err_skip, m_eskip);
    chk("err_pattern", err_pattern, m_epat);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      if (step_stb === 1'b1) stb_seen++;
      check_all();
    end
  endtask

  task automatic hold(int v, int n);
    ph_in = v[3:0];
    tick(n);
  endtask

  initial begin
    int cur, r, v;
    edge_n = 0; last_step = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    ph_in = 4'b0011;
    tick(6);
    chk("lock_edge6", locked, 0);
    tick(1);
    chk("lock_edge7", locked, 1);
    tick(13);
    chk("lock_no_step", stb_seen, 0);
    chk("lock_pos", $signed(position), 0);

    stb_seen = 0;
    hold(6, 20); hold(12, 20); hold(9, 20); hold(3, 20);
    chk("fwd_pulses", stb_seen, 4);
    chk("fwd_pos", $signed(position), 4);
    chk("fwd_dir", step_dir, 0);
    tick(86);
    chk("moving_99", moving, 1);
    tick(1);
    chk("moving_100", moving, 0);

    pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
    stb_seen = 0;
    hold(9, 20); hold(12, 20); hold(6, 20);
    chk("rev_pulses", stb_seen, 3);
    chk("rev_pos", $signed(position), -3);
    chk("rev_dir", step_dir, 1);
    hold(3, 20); hold(9, 20); hold(12, 20); hold(6, 20); hold(3, 20);
    chk("rev_pos_min", $signed(position), -8);
    hold(9, 20);
    chk("rev_wrap", $signed(position), 7);

    hold(3, 20);
    stb_seen = 0;
    hold(6, 3); hold(3, 20);
    chk("glitch_steps", stb_seen, 0);
    chk("glitch_skip", err_skip, 0);
    hold(12, 20);
    chk("skip_flag", err_skip, 1);
    chk("skip_pos", $signed(position), -8);
    hold(9, 20);
    chk("after_skip", $signed(position), -7);

    hold(3, 20);
    hold(7, 20);
    chk("illegal_flag", err_pattern, 1);
    chk("illegal_unlock", locked, 0);
    hold(0, 20);
    chk("off_keeps", err_pattern, 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("clr_pat", err_pattern, 0);
    chk("clr_skip", err_skip, 0);
    stb_seen = 0;
    hold(3, 20);
    chk("relock", locked, 1);
    chk("relock_steps", stb_seen, 0);

    ph_in = 4'b0110;
    tick(6);
    pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
    chk("clr_step_stb", step_stb, 1);
    chk("clr_step_pos", $signed(position), 0);
    tick(13);
    ph_in = 4'b1001;
    tick(6);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("set_over_clr", err_skip, 1);
    tick(13);

    ph_in = 4'b1100;
    tick(3);
    rst = 1'b1; tick(1);
    chk("rst_locked", locked, 0);
    chk("rst_pos", $signed(position), 0);
    chk("rst_skip", err_skip, 0);
    chk("rst_dir", step_dir, 0);
    rst = 1'b0;
    tick(20);

    cur = 2;
    repeat (300) begin
      r = $urandom_range(0, 19);
      if (r < 7) begin cur = (cur + 1) % 4; v = pats[cur]; end
      else if (r < 14) begin cur = (cur + 3) % 4; v = pats[cur]; end
      else if (r < 16) begin cur = (cur + 2) % 4; v = pats[cur]; end
      else if (r < 18) v = 0;
      else v = $urandom_range(0, 15);
      ph_in = v[3:0];
      repeat ($urandom_range(1, 14)) begin
        pos_clr = ($urandom_range(0, 31) == 0);
        err_clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick(1);
      end
      pos_clr = 1'b0; err_clr = 1'b0; rst = 1'b0;
    end
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
